// File: rtl/branch_resolve.sv
// branch_resolve: multi-cycle RISC-V conditional branch resolver.
//
// The request is captured in IDLE. SUB registers a 33-bit difference of the
// operands. JUDGE saturates that difference to a 16-bit signed "imm" and
// evaluates the comparison class against it, which produces taken and
// next_pc. DONE holds every result until the consumer accepts it.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   in_valid / in_ready           request handshake (in_ready only in IDLE)
//   funct3, rs1, rs2, pc, offset  branch request fields
//   out_valid / out_ready         result handshake (out_valid only in DONE)
//   judge_imm, judge_btype        saturated comparison value and its class
//   taken, next_pc, illegal       branch outcome
//
// Optional feature macro: BRANCH_RESOLVE_STATS_EN
//   When defined, this adds taken_count / resolved_count outputs. These are
//   32-bit wrapping counters of accepted results.
module branch_resolve #(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        funct3,
    input  logic [XLEN-1:0]   rs1,
    input  logic [XLEN-1:0]   rs2,
    input  logic [XLEN-1:0]   pc,
    input  logic [XLEN-1:0]   offset,
    output logic signed [15:0] judge_imm,
    output logic [1:0]        judge_btype,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              taken,
    output logic [XLEN-1:0]   next_pc,
    output logic              illegal
`ifdef BRANCH_RESOLVE_STATS_EN
    ,
    output logic [31:0]       taken_count,
    output logic [31:0]       resolved_count
`endif
);

    typedef enum logic [1:0] {IDLE, SUB, JUDGE, DONE} state_t;

    state_t st, st_nxt;

    logic [2:0]             f3_q;
    logic [XLEN-1:0]        a_q, b_q, pc_q, off_q;
    logic signed [XLEN:0]   diff_q;

    logic                   ill_c, uns_c, swap_c, taken_c;
    logic [XLEN:0]          ea, eb, diff_c;
    logic [1:0]             btype_c;
    logic signed [15:0]     imm_c;

    assign in_ready  = (st == IDLE);
    assign out_valid = (st == DONE);

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) st <= IDLE;
        else     st <= st_nxt;
    end

    always_comb begin
        st_nxt = st;
        case (st)
            IDLE:    if (in_valid) st_nxt = SUB;
            SUB:     st_nxt = JUDGE;
            JUDGE:   st_nxt = DONE;
            DONE:    if (out_ready) st_nxt = IDLE;
            default: st_nxt = IDLE;
        endcase
    end

    // ---------------- decode / arithmetic ----------------
    always_comb begin
        ill_c  = (f3_q == 3'b010) || (f3_q == 3'b011);
        uns_c  = f3_q[1];                                // bltu / bgeu
        swap_c = (f3_q == 3'b100) || (f3_q == 3'b110);   // blt / bltu compute rs2-rs1
        ea     = uns_c ? {1'b0, a_q} : {a_q[XLEN-1], a_q};
        eb     = uns_c ? {1'b0, b_q} : {b_q[XLEN-1], b_q};
        diff_c = swap_c ? (eb - ea) : (ea - eb);

        case (f3_q)
            3'b001:         btype_c = 2'd3;   // bne: != 0
            3'b100, 3'b110: btype_c = 2'd2;   // blt/bltu: > 0
            3'b101, 3'b111: btype_c = 2'd1;   // bge/bgeu: >= 0
            default:        btype_c = 2'd0;   // beq and illegal codes
        endcase

        // Saturate to 16 bits while keeping the sign and the zero-ness.
        if (ill_c)                          imm_c = 16'sd0;
        else if (diff_q > 33'sd32767)       imm_c = 16'sh7fff;
        else if (diff_q < -33'sd32768)      imm_c = 16'sh8000;
        else                                imm_c = diff_q[15:0];

        case (btype_c)
            2'd0:    taken_c = (imm_c == 16'sd0);
            2'd1:    taken_c = !imm_c[15];
            2'd2:    taken_c = !imm_c[15] && (imm_c != 16'sd0);
            default: taken_c = (imm_c != 16'sd0);
        endcase
        if (ill_c) taken_c = 1'b0;
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            f3_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            pc_q        <= '0;
            off_q       <= '0;
            diff_q      <= '0;
            judge_imm   <= '0;
            judge_btype <= '0;
            taken       <= 1'b0;
            next_pc     <= '0;
            illegal     <= 1'b0;
        end else begin
            case (st)
                IDLE: if (in_valid) begin
                    f3_q  <= funct3;
                    a_q   <= rs1;
                    b_q   <= rs2;
                    pc_q  <= pc;
                    off_q <= offset;
                end
                SUB: diff_q <= diff_c;
                JUDGE: begin
                    judge_imm   <= imm_c;
                    judge_btype <= ill_c ? 2'd0 : btype_c;
                    taken       <= taken_c;
                    next_pc     <= taken_c ? (pc_q + off_q) : (pc_q + XLEN'(4));
                    illegal     <= ill_c;
                end
                default: ;
            endcase
        end
    end

`ifdef BRANCH_RESOLVE_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            taken_count    <= '0;
            resolved_count <= '0;
        end else if (out_valid && out_ready) begin
            resolved_count <= resolved_count + 32'd1;
            taken_count    <= taken_count + {31'd0, taken};
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// tb_branch_resolve: directed and randomized checks of branch_resolve.
// The reference model evaluates branch semantics directly (signed/unsigned
// compares) and derives the saturated judge value from a wide integer
// difference.
module tb_branch_resolve;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst, in_valid, in_ready, out_valid, out_ready, taken, illegal;
    logic [2:0]        funct3;
    logic [31:0]       rs1, rs2, pc, offset, next_pc;
    logic signed [15:0] judge_imm;
    logic [1:0]        judge_btype;
`ifdef BRANCH_RESOLVE_STATS_EN
    logic [31:0]       taken_count, resolved_count;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    branch_resolve #(.XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .funct3(funct3), .rs1(rs1), .rs2(rs2), .pc(pc), .offset(offset),
        .judge_imm(judge_imm), .judge_btype(judge_btype),
        .out_valid(out_valid), .out_ready(out_ready),
        .taken(taken), .next_pc(next_pc), .illegal(illegal)
`ifdef BRANCH_RESOLVE_STATS_EN
        , .taken_count(taken_count), .resolved_count(resolved_count)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: branch semantics straight from the ISA plus wide-integer saturation.
    function automatic void model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                  output logic signed [15:0] imm, output logic [1:0] bt,
                                  output logic tk, output logic ill);
        longint sa, sb, ua, ub, d;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        ill = 1'b0;
        case (f3)
            3'd0: begin d = sa - sb; bt = 2'd0; tk = (a == b); end
            3'd1: begin d = sa - sb; bt = 2'd3; tk = (a != b); end
            3'd4: begin d = sb - sa; bt = 2'd2; tk = (sa < sb); end
            3'd5: begin d = sa - sb; bt = 2'd1; tk = (sa >= sb); end
            3'd6: begin d = ub - ua; bt = 2'd2; tk = (a < b); end
            3'd7: begin d = ua - ub; bt = 2'd1; tk = (a >= b); end
            default: begin d = 0; bt = 2'd0; tk = 1'b0; ill = 1'b1; end
        endcase
        if (d > 32767)       imm = 16'sh7fff;
        else if (d < -32768) imm = 16'sh8000;
        else                 imm = 16'(d);
    endfunction

    task automatic chk_out(input string tag, input logic signed [15:0] ei, input logic [1:0] eb,
                           input logic et, input logic [31:0] enpc, input logic eill);
        chk({tag, "_imm"},   64'(judge_imm),   64'(ei));
        chk({tag, "_btype"}, 64'(judge_btype), 64'(eb));
        chk({tag, "_taken"}, 64'(taken),       64'(et));
        chk({tag, "_nextpc"},64'(next_pc),     64'(enpc));
        chk({tag, "_illegal"},64'(illegal),    64'(eill));
    endtask

    // One full request: accept, busy phases (with ignored in_valid), DONE held
    // for 'hold' extra cycles, then handshake back to IDLE.
    task automatic do_req(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] p, input logic [31:0] o,
                          input int hold, output logic tk_o);
        logic signed [15:0] ei;
        logic [1:0] eb;
        logic et, eill;
        logic [31:0] enpc;
        model(f3, a, b, ei, eb, et, eill);
        enpc = et ? (p + o) : (p + 32'd4);
        tk_o = et;
        @(negedge clk);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'(1));
        in_valid = 1'b1; funct3 = f3; rs1 = a; rs2 = b; pc = p; offset = o;
        @(negedge clk);                    // SUB
        funct3 = 3'($urandom); rs1 = $urandom; rs2 = $urandom; pc = $urandom; offset = $urandom;
        chk({tag, "_busy"},  64'(in_ready),  64'(0));
        chk({tag, "_early"}, 64'(out_valid), 64'(0));
        @(negedge clk);                    // JUDGE
        chk({tag, "_early2"}, 64'(out_valid), 64'(0));
        in_valid  = 1'b0;
        out_ready = (hold == 0);
        @(negedge clk);                    // DONE
        chk({tag, "_latency"}, 64'(out_valid), 64'(1));
        chk_out(tag, ei, eb, et, enpc, eill);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, "_hold_valid"}, 64'(out_valid), 64'(1));
            chk({tag, "_hold_ready"}, 64'(in_ready),  64'(0));
            chk_out({tag, "_hold"}, ei, eb, et, enpc, eill);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk({tag, "_drop"}, 64'(out_valid), 64'(0));
        chk({tag, "_idle"}, 64'(in_ready),  64'(1));
        out_ready = 1'b0;
    endtask

    initial begin
        logic tk;
        logic [31:0] a, b;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        funct3 = '0; rs1 = '0; rs2 = '0; pc = '0; offset = '0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready",  64'(in_ready),  64'(1));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk_out("rst", 16'sd0, 2'd0, 1'b0, 32'd0, 1'b0);
        rst = 1'b0;

        // Directed vectors
        do_req("beq_eq",   3'd0, 32'd5, 32'd5, 32'h100, 32'h20, 0, tk);
        do_req("blt_min",  3'd4, 32'h8000_0000, 32'd1, 32'h300, 32'h40, 0, tk);
        do_req("bltu_min", 3'd6, 32'h8000_0000, 32'd1, 32'h300, 32'h40, 0, tk);
        do_req("bge_neg",  3'd5, 32'hFFFF_FF9D, 32'd0, 32'h200, 32'h10, 0, tk);
        do_req("bne_wrap", 3'd1, 32'd1, 32'd2, 32'hFFFF_FFFC, 32'd8, 0, tk);
        do_req("ill_010",  3'd2, 32'd7, 32'd7, 32'h400, 32'h8, 0, tk);
        do_req("ill_011",  3'd3, 32'd1, 32'd9, 32'h500, 32'h8, 1, tk);
        do_req("bgeu_hold",3'd7, 32'hFFFF_0000, 32'd3, 32'h600, 32'hFFFF_FFF0, 5, tk);
        do_req("bltu_sat", 3'd6, 32'd0, 32'hFFFF_FFFF, 32'h700, 32'h4, 0, tk);

        // Randomized requests, biased to hit equality and the saturation edges
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = a;
                1:       b = a + 32'($urandom_range(0, 70000)) - 32'd35000;
                2:       b = a ^ 32'h8000_0000;
                default: b = $urandom;
            endcase
            do_req("rand", 3'($urandom_range(0, 7)), a, b, $urandom, $urandom,
                   int'($urandom_range(0, 2)), tk);
        end

        // Reset while in SUB discards the request
        @(negedge clk);
        in_valid = 1'b1; funct3 = 3'd0; rs1 = 32'd1; rs2 = 32'd1; pc = 32'h800; offset = 32'h8;
        @(negedge clk);
        in_valid = 1'b0; rst = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_in_ready",  64'(in_ready),  64'(1));
        chk("midrst_out_valid", 64'(out_valid), 64'(0));
        chk_out("midrst", 16'sd0, 2'd0, 1'b0, 32'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("midrst_no_valid", 64'(out_valid), 64'(0));
        end
        out_ready = 1'b0;

`ifdef BRANCH_RESOLVE_STATS_EN
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("stats_clr_taken", 64'(taken_count),    64'(0));
        chk("stats_clr_res",   64'(resolved_count), 64'(0));
        for (int i = 0; i < 3; i++) do_req("st_t", 3'd0, 32'd4, 32'd4, 32'h10, 32'h8, 0, tk);
        for (int i = 0; i < 2; i++) do_req("st_n", 3'd1, 32'd4, 32'd4, 32'h10, 32'h8, 0, tk);
        chk("stats_taken", 64'(taken_count),    64'(3));
        chk("stats_res",   64'(resolved_count), 64'(5));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("stats_rst_taken", 64'(taken_count),    64'(0));
        chk("stats_rst_res",   64'(resolved_count), 64'(0));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
